// File: rtl/regfile_sb.sv
// Parametrised register file with two bypassed read ports, a general write
// port, a dedicated PC write port and a per-register busy scoreboard.
module regfile_sb #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 7,
  parameter logic [DATA_W-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              we_r,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              we_pc,
  input  logic [DATA_W-1:0] pc_data,
  output logic [DATA_W-1:0] pc_out,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ack,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   NREGS_W = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W-1:0] PC_A    = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;

  logic wr_valid;
  logic rsv_valid;
  logic gen_wr_pc;
  logic pc_bypass;

  assign wr_valid  = {1'b0, wr_addr} < NREGS_W;
  assign rsv_valid = {1'b0, rsv_addr} < NREGS_W;
  assign gen_wr_pc = we_r && (wr_addr == PC_A);
  assign pc_bypass = we_pc && !gen_wr_pc;
  assign pc_out    = regs[PC_IDX];

  // Out-of-range read addresses match no entry and fall through to zero/not-busy.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    rd_busy_a = 1'b0;
    rd_busy_b = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) begin
        rd_data_a = regs[i];
        rd_busy_a = busy[i];
      end
      if (rd_addr_b == ADDR_W'(i)) begin
        rd_data_b = regs[i];
        rd_busy_b = busy[i];
      end
    end
    if (pc_bypass && rd_addr_a == PC_A) rd_data_a = pc_data;
    if (pc_bypass && rd_addr_b == PC_A) rd_data_b = pc_data;
    if (we_r && wr_valid && wr_addr == rd_addr_a) begin
      rd_data_a = wr_data;
      rd_busy_a = 1'b0;
    end
    if (we_r && wr_valid && wr_addr == rd_addr_b) begin
      rd_data_b = wr_data;
      rd_busy_b = 1'b0;
    end
  end

  // Later assignments take priority: general write over PC write, reserve-set over write-clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == PC_IDX) ? PC_RST : '0;
      busy     <= '0;
      rsv_ack  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rsv_ack <= 1'b0;
      if (we_pc) regs[PC_IDX] <= pc_data;
      for (int i = 0; i < NREGS; i++) begin
        if (we_r && wr_addr == ADDR_W'(i)) begin
          regs[i] <= wr_data;
          busy[i] <= 1'b0;
        end
      end
      for (int i = 0; i < NREGS; i++) begin
        if (rsv_en && rsv_addr == ADDR_W'(i) && !busy[i]) begin
          busy[i] <= 1'b1;
          rsv_ack <= 1'b1;
        end
      end
      if ((we_r && !wr_valid) || (rsv_en && !rsv_valid))
        addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset, bypass, PC priority,
// scoreboard reservations and out-of-range address handling.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        we_r;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        we_pc;
  logic [15:0] pc_data;
  logic [15:0] pc_out;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic        rsv_ack;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  regfile_sb #(
    .DATA_W(16), .NREGS(8), .ADDR_W(4), .PC_IDX(7), .PC_RST(16'h0040)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .we_r(we_r), .wr_addr(wr_addr), .wr_data(wr_data),
    .we_pc(we_pc), .pc_data(pc_data), .pc_out(pc_out),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic rst_v,
                               input logic [3:0] ra, input logic [3:0] rb,
                               input logic wer, input logic [3:0] wa, input logic [15:0] wd,
                               input logic wep, input logic [15:0] pd,
                               input logic rse, input logic [3:0] rsa);
    rst_n = rst_v; rd_addr_a = ra; rd_addr_b = rb;
    we_r = wer; wr_addr = wa; wr_data = wd;
    we_pc = wep; pc_data = pd;
    rsv_en = rse; rsv_addr = rsa;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      $error("[TB] %s", tag);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_rd_a0", rd_data_a, 16'h0000);
    checkOutput("rst_rd_b7", rd_data_b, 16'h0040);
    checkOutput("rst_pc_out", pc_out, 16'h0040);
    checkOutput("rst_busy_a", {15'd0, rd_busy_a}, 16'd0);
    checkOutput("rst_busy_b", {15'd0, rd_busy_b}, 16'd0);
    checkOutput("rst_addr_err", {15'd0, addr_err}, 16'd0);
    checkOutput("rst_rsv_ack", {15'd0, rsv_ack}, 16'd0);

    applyStimulus(1, 3, 0, 1, 3, 16'hBEEF, 0, 0, 0, 0);
    checkOutput("bypass_a3", rd_data_a, 16'hBEEF);
    checkOutput("pre_write_b0", rd_data_b, 16'h0000);
    nextCycle();
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stored_a3", rd_data_a, 16'hBEEF);

    applyStimulus(1, 3, 7, 1, 7, 16'h1234, 1, 16'h0010, 0, 0);
    checkOutput("pc_conflict_bypass_b", rd_data_b, 16'h1234);
    nextCycle();
    applyStimulus(1, 3, 7, 0, 0, 0, 1, 16'h0011, 0, 0);
    checkOutput("pc_conflict_pc_out", pc_out, 16'h1234);
    checkOutput("pc_bypass_b", rd_data_b, 16'h0011);
    nextCycle();
    applyStimulus(1, 3, 7, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("pc_write_pc_out", pc_out, 16'h0011);

    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 1, 5);
    checkOutput("pre_rsv_busy5", {15'd0, rd_busy_a}, 16'd0);
    nextCycle();
    checkOutput("rsv_ack_first", {15'd0, rsv_ack}, 16'd1);
    checkOutput("rsv_busy5", {15'd0, rd_busy_a}, 16'd1);
    nextCycle();
    applyStimulus(1, 5, 0, 1, 5, 16'h00AA, 0, 0, 0, 0);
    checkOutput("rsv_ack_refused", {15'd0, rsv_ack}, 16'd0);
    checkOutput("write_clears_busy_comb", {15'd0, rd_busy_a}, 16'd0);
    checkOutput("write_bypass_5", rd_data_a, 16'h00AA);
    nextCycle();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy5_released", {15'd0, rd_busy_a}, 16'd0);
    checkOutput("data5_stored", rd_data_a, 16'h00AA);

    applyStimulus(1, 2, 0, 1, 2, 16'h5555, 0, 0, 1, 2);
    nextCycle();
    applyStimulus(1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rsv_wr_data2", rd_data_a, 16'h5555);
    checkOutput("rsv_wr_busy2", {15'd0, rd_busy_a}, 16'd1);
    checkOutput("rsv_wr_ack", {15'd0, rsv_ack}, 16'd1);
    applyStimulus(0, 2, 3, 0, 0, 0, 0, 0, 1, 4);
    nextCycle();
    applyStimulus(1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midrsv_rst_busy2", {15'd0, rd_busy_a}, 16'd0);
    checkOutput("midrsv_rst_data2", rd_data_a, 16'h0000);
    checkOutput("midrsv_rst_data3", rd_data_b, 16'h0000);
    checkOutput("midrsv_rst_ack", {15'd0, rsv_ack}, 16'd0);
    checkOutput("midrsv_rst_pc", pc_out, 16'h0040);

    applyStimulus(1, 9, 1, 1, 9, 16'hFFFF, 0, 0, 0, 0);
    checkOutput("oob_no_bypass", rd_data_a, 16'h0000);
    nextCycle();
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("oob_addr_err", {15'd0, addr_err}, 16'd1);
    checkOutput("oob_rd_data", rd_data_a, 16'h0000);
    checkOutput("oob_rd_busy", {15'd0, rd_busy_a}, 16'd0);
    checkOutput("oob_no_alias_r1", rd_data_b, 16'h0000);
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 1, 12);
    nextCycle();
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("oob_rsv_ack", {15'd0, rsv_ack}, 16'd0);
    nextCycle();
    nextCycle();
    checkOutput("addr_err_sticky", {15'd0, addr_err}, 16'd1);
    applyStimulus(0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("addr_err_cleared", {15'd0, addr_err}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
